// File: rtl/pit_fib_port.sv
// PIT-side endpoint of the PIT<->FIB link.
// Sends interests to the FIB and buffers one FIB return for the PIT table.
module pit_fib_port #(
    parameter int DATA_BYTES = 4,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic [63:0]             req_prefix,
    input  logic [5:0]              req_len,
    output logic                    req_ready,
    output logic [63:0]             pit_in_prefix,
    output logic [5:0]              pit_in_len,
    output logic                    fib_out_bit,
    output logic                    start_send_to_pit,
    output logic                    rejected,
    input  logic [63:0]             pit_out_prefix,
    input  logic [5:0]              pit_out_len,
    input  logic                    prefix_ready,
    input  logic [7:0]              out_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [63:0]             rsp_prefix,
    output logic [5:0]              rsp_len,
    output logic [8*DATA_BYTES-1:0] rsp_data,
    output logic [CNT_W-1:0]        reject_count
);

    localparam int CW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_BYTES - 1);

    typedef enum logic {T_IDLE, T_SEND} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_DATA, R_HOLD} rx_state_t;

    tx_state_t t_state, t_next;
    rx_state_t r_state, r_next;

    logic [CW-1:0] cnt;
    logic          tx_go;
    logic          rx_cap;
    logic          rx_rej;
    logic [63:0]   req_mask;

    always_comb begin
        t_next   = t_state;
        tx_go    = 1'b0;
        req_mask = ~({64{1'b1}} << req_len);
        unique case (t_state)
            T_IDLE: begin
                // A zero-length request is consumed without a strobe.
                tx_go = req_valid && (req_len != 6'd0);
                if (tx_go) t_next = T_SEND;
            end
            T_SEND: t_next = T_IDLE;
            default: t_next = T_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        rx_cap = prefix_ready && (r_state == R_IDLE) && (pit_out_len != 6'd0);
        rx_rej = prefix_ready && !rx_cap;
        unique case (r_state)
            R_IDLE: if (rx_cap) r_next = R_DATA;
            R_DATA: if (cnt == LAST) r_next = R_HOLD;
            R_HOLD: if (rsp_ready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_state       <= T_IDLE;
            req_ready     <= 1'b1;
            fib_out_bit   <= 1'b0;
            pit_in_prefix <= '0;
            pit_in_len    <= '0;
        end else begin
            t_state     <= t_next;
            req_ready   <= (t_next == T_IDLE);
            fib_out_bit <= tx_go;
            if (tx_go) begin
                pit_in_prefix <= req_prefix & req_mask;
                pit_in_len    <= req_len;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= R_IDLE;
            cnt               <= '0;
            start_send_to_pit <= 1'b1;
            rsp_valid         <= 1'b0;
            rejected          <= 1'b0;
            rsp_prefix        <= '0;
            rsp_len           <= '0;
            rsp_data          <= '0;
            reject_count      <= '0;
        end else begin
            r_state           <= r_next;
            start_send_to_pit <= (r_next == R_IDLE);
            rsp_valid         <= (r_next == R_HOLD);
            rejected          <= rx_rej;
            if (rx_rej && (reject_count != {CNT_W{1'b1}}))
                reject_count <= reject_count + 1'b1;
            if (rx_cap) begin
                rsp_prefix <= pit_out_prefix;
                rsp_len    <= pit_out_len;
                cnt        <= '0;
            end
            if (r_state == R_DATA) begin
                rsp_data[{cnt, 3'b000} +: 8] <= out_data;
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pit_fib_port.sv
// Scoreboard bench for pit_fib_port: interests, returns, rejects, resets.
// A second instance with a 2-bit reject counter checks saturation.
module tb_pit_fib_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [63:0] req_prefix;
    logic [5:0]  req_len;
    logic        req_ready;
    logic [63:0] pit_in_prefix;
    logic [5:0]  pit_in_len;
    logic        fib_out_bit;
    logic        start_send_to_pit;
    logic        rejected;
    logic [63:0] pit_out_prefix;
    logic [5:0]  pit_out_len;
    logic        prefix_ready;
    logic [7:0]  out_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_prefix;
    logic [5:0]  rsp_len;
    logic [31:0] rsp_data;
    logic [7:0]  reject_count;

    logic        s_req_ready, s_fib_out_bit, s_start, s_rejected, s_rsp_valid;
    logic [63:0] s_pit_in_prefix, s_rsp_prefix;
    logic [5:0]  s_pit_in_len, s_rsp_len;
    logic [31:0] s_rsp_data;
    logic [1:0]  s_reject_count;

    always #5 clk = ~clk;

    pit_fib_port #(.DATA_BYTES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_prefix(req_prefix), .req_len(req_len),
        .req_ready(req_ready),
        .pit_in_prefix(pit_in_prefix), .pit_in_len(pit_in_len),
        .fib_out_bit(fib_out_bit), .start_send_to_pit(start_send_to_pit),
        .rejected(rejected),
        .pit_out_prefix(pit_out_prefix), .pit_out_len(pit_out_len),
        .prefix_ready(prefix_ready), .out_data(out_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_prefix(rsp_prefix), .rsp_len(rsp_len), .rsp_data(rsp_data),
        .reject_count(reject_count)
    );

    pit_fib_port #(.DATA_BYTES(4), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_prefix(req_prefix), .req_len(req_len),
        .req_ready(s_req_ready),
        .pit_in_prefix(s_pit_in_prefix), .pit_in_len(s_pit_in_len),
        .fib_out_bit(s_fib_out_bit), .start_send_to_pit(s_start),
        .rejected(s_rejected),
        .pit_out_prefix(pit_out_prefix), .pit_out_len(pit_out_len),
        .prefix_ready(prefix_ready), .out_data(out_data),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_prefix(s_rsp_prefix), .rsp_len(s_rsp_len), .rsp_data(s_rsp_data),
        .reject_count(s_reject_count)
    );

    typedef struct packed {
        logic [63:0] p;
        logic [5:0]  l;
    } tx_exp_t;

    typedef struct packed {
        logic [63:0] p;
        logic [5:0]  l;
        logic [31:0] d;
    } rx_exp_t;

    tx_exp_t tx_q[$];
    rx_exp_t rx_q[$];
    tx_exp_t te;
    rx_exp_t re;
    int checks   = 0;
    int failures = 0;
    int rej_exp  = 0;

    function automatic logic [63:0] trim(input logic [63:0] p, input int len);
        logic [63:0] r;
        r = p;
        for (int b = 0; b < 64; b++)
            if (b >= len) r[b] = 1'b0;
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid      = 1'b0;
        req_prefix     = '0;
        req_len        = '0;
        pit_out_prefix = '0;
        pit_out_len    = '0;
        prefix_ready   = 1'b0;
        out_data       = '0;
        rsp_ready      = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (5) step();
        rst = 1'b0;
        step();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++; if (start_send_to_pit !== 1'b1) begin failures++; $display("FAIL reset_start got %b want 1", start_send_to_pit); end
        checks++; if (fib_out_bit !== 1'b0) begin failures++; $display("FAIL reset_fib_out_bit got %b want 0", fib_out_bit); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rejected !== 1'b0) begin failures++; $display("FAIL reset_rejected got %b want 0", rejected); end
        checks++; if (reject_count !== 8'd0) begin failures++; $display("FAIL reset_reject_count got %0d want 0", reject_count); end
        checks++; if (rsp_data !== 32'd0) begin failures++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        checks++; if (pit_in_prefix !== 64'd0) begin failures++; $display("FAIL reset_pit_in_prefix got %h want 0", pit_in_prefix); end
    endtask

    task automatic test_interest();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL int_ready_pre got %b want 1", req_ready); end
        req_valid  = 1'b1;
        req_prefix = 64'hFFFF_FFFF_FFFF_FFFF;
        req_len    = 6'd16;
        tx_q.push_back('{trim(req_prefix, 16), 6'd16});
        step();
        req_valid = 1'b0;
        checks++; if (fib_out_bit !== 1'b1) begin failures++; $display("FAIL int_strobe got %b want 1", fib_out_bit); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL int_ready_busy got %b want 0", req_ready); end
        if (fib_out_bit === 1'b1 && tx_q.size() > 0) begin
            te = tx_q.pop_front();
            checks++; if (pit_in_prefix !== te.p) begin failures++; $display("FAIL int_prefix got %h want %h", pit_in_prefix, te.p); end
            checks++; if (pit_in_len !== te.l) begin failures++; $display("FAIL int_len got %0d want %0d", pit_in_len, te.l); end
        end
        step();
        checks++; if (fib_out_bit !== 1'b0) begin failures++; $display("FAIL int_strobe_end got %b want 0", fib_out_bit); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL int_ready_back got %b want 1", req_ready); end
        checks++; if (pit_in_prefix !== 64'h0000_0000_0000_FFFF) begin failures++; $display("FAIL int_prefix_hold got %h want 000000000000ffff", pit_in_prefix); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) begin
                checks++;
                if (fib_out_bit !== logic'(k % 2 == 1)) begin
                    failures++;
                    $display("FAIL b2b_strobe k=%0d got %b want %b", k, fib_out_bit, (k % 2 == 1));
                end
                if (fib_out_bit === 1'b1) begin
                    checks++;
                    if (tx_q.size() == 0) begin
                        failures++;
                        $display("FAIL b2b_unexpected_strobe k=%0d got strobe want none", k);
                    end else begin
                        te = tx_q.pop_front();
                        if (pit_in_prefix !== te.p || pit_in_len !== te.l) begin
                            failures++;
                            $display("FAIL b2b_payload got %h/%0d want %h/%0d", pit_in_prefix, pit_in_len, te.p, te.l);
                        end
                    end
                end
            end
            if (k < 4) begin
                req_valid  = 1'b1;
                req_prefix = {$urandom, $urandom};
                req_len    = 6'($urandom_range(1, 63));
                if (req_ready === 1'b1)
                    tx_q.push_back('{trim(req_prefix, int'(req_len)), req_len});
            end else begin
                req_valid = 1'b0;
            end
            step();
        end
        checks++; if (tx_q.size() != 0) begin failures++; $display("FAIL b2b_lost got %0d pending want 0", tx_q.size()); end
        req_valid  = 1'b1;
        req_prefix = 64'hFFFF_FFFF_FFFF_FFFF;
        req_len    = 6'd0;
        step();
        req_valid = 1'b0;
        checks++; if (fib_out_bit !== 1'b0) begin failures++; $display("FAIL len0_strobe got %b want 0", fib_out_bit); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL len0_ready got %b want 1", req_ready); end
        step();
        checks++; if (fib_out_bit !== 1'b0) begin failures++; $display("FAIL len0_strobe2 got %b want 0", fib_out_bit); end
    endtask

    task automatic test_return();
        logic [31:0] d;
        d = 32'h4433_2211;
        prefix_ready   = 1'b1;
        pit_out_prefix = 64'hA5;
        pit_out_len    = 6'd8;
        rx_q.push_back('{64'hA5, 6'd8, d});
        step();
        prefix_ready = 1'b0;
        checks++; if (start_send_to_pit !== 1'b0) begin failures++; $display("FAIL ret_start_busy got %b want 0", start_send_to_pit); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL ret_valid_early i=%0d got %b want 0", i, rsp_valid); end
            out_data = d[8*i +: 8];
            step();
        end
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL ret_valid got %b want 1", rsp_valid); end
        if (rsp_valid === 1'b1 && rx_q.size() > 0) begin
            re = rx_q.pop_front();
            checks++; if (rsp_data !== re.d) begin failures++; $display("FAIL ret_data got %h want %h", rsp_data, re.d); end
            checks++; if (rsp_len !== re.l || rsp_prefix !== re.p) begin failures++; $display("FAIL ret_hdr got %h/%0d want %h/%0d", rsp_prefix, rsp_len, re.p, re.l); end
        end
        step();
        checks++; if (rsp_valid !== 1'b1 || start_send_to_pit !== 1'b0) begin failures++; $display("FAIL ret_hold got %b/%b want 1/0", rsp_valid, start_send_to_pit); end
        step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL ret_consume_valid got %b want 0", rsp_valid); end
        checks++; if (start_send_to_pit !== 1'b1) begin failures++; $display("FAIL ret_consume_start got %b want 1", start_send_to_pit); end
        checks++; if (rsp_data !== d) begin failures++; $display("FAIL ret_data_hold got %h want %h", rsp_data, d); end
    endtask

    task automatic test_rejects();
        logic [31:0] d;
        d = 32'hD4C3_B2A1;
        prefix_ready   = 1'b1;
        pit_out_prefix = 64'h1234;
        pit_out_len    = 6'd12;
        rx_q.push_back('{64'h1234, 6'd12, d});
        step();
        prefix_ready = 1'b0;
        out_data     = d[7:0];
        step();
        out_data       = d[15:8];
        prefix_ready   = 1'b1;
        pit_out_prefix = 64'hDEAD;
        pit_out_len    = 6'd5;
        rej_exp++;
        step();
        prefix_ready = 1'b0;
        checks++; if (rejected !== 1'b1) begin failures++; $display("FAIL rej_data_pulse got %b want 1", rejected); end
        out_data = d[23:16];
        step();
        checks++; if (rejected !== 1'b0) begin failures++; $display("FAIL rej_data_width got %b want 0", rejected); end
        out_data = d[31:24];
        step();
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rej_valid got %b want 1", rsp_valid); end
        if (rsp_valid === 1'b1 && rx_q.size() > 0) begin
            re = rx_q.pop_front();
            checks++; if (rsp_data !== re.d || rsp_prefix !== re.p || rsp_len !== re.l) begin failures++; $display("FAIL rej_capture got %h/%h/%0d want %h/%h/%0d", rsp_data, rsp_prefix, rsp_len, re.d, re.p, re.l); end
        end
        prefix_ready = 1'b1;
        rej_exp++;
        step();
        prefix_ready = 1'b0;
        checks++; if (rejected !== 1'b1) begin failures++; $display("FAIL rej_hold_pulse got %b want 1", rejected); end
        step();
        checks++; if (rejected !== 1'b0) begin failures++; $display("FAIL rej_hold_width got %b want 0", rejected); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || start_send_to_pit !== 1'b1) begin failures++; $display("FAIL rej_release got %b/%b want 0/1", rsp_valid, start_send_to_pit); end
        prefix_ready   = 1'b1;
        pit_out_prefix = 64'hBEEF;
        pit_out_len    = 6'd0;
        rej_exp++;
        step();
        prefix_ready = 1'b0;
        checks++; if (rejected !== 1'b1) begin failures++; $display("FAIL rej_len0_pulse got %b want 1", rejected); end
        checks++; if (start_send_to_pit !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rej_len0_state got %b/%b want 1/0", start_send_to_pit, rsp_valid); end
        checks++; if (rsp_data !== d) begin failures++; $display("FAIL rej_data_kept got %h want %h", rsp_data, d); end
        checks++; if (reject_count !== 8'(rej_exp)) begin failures++; $display("FAIL rej_count3 got %0d want %0d", reject_count, rej_exp); end
        for (int i = 0; i < 2; i++) begin
            prefix_ready = 1'b1;
            rej_exp++;
            step();
            prefix_ready = 1'b0;
            step();
        end
        checks++; if (reject_count !== 8'(rej_exp)) begin failures++; $display("FAIL rej_count5 got %0d want %0d", reject_count, rej_exp); end
        checks++; if (s_reject_count !== 2'((rej_exp > 3) ? 3 : rej_exp)) begin failures++; $display("FAIL rej_saturate got %0d want %0d", s_reject_count, (rej_exp > 3) ? 3 : rej_exp); end
    endtask

    task automatic test_concurrent();
        logic [31:0] d;
        d = 32'hCCBB_AA99;
        req_valid      = 1'b1;
        req_prefix     = 64'h1234_5678_9ABC_DEF0;
        req_len        = 6'd20;
        tx_q.push_back('{trim(req_prefix, 20), 6'd20});
        prefix_ready   = 1'b1;
        pit_out_prefix = 64'hCAFE;
        pit_out_len    = 6'd16;
        rx_q.push_back('{64'hCAFE, 6'd16, d});
        step();
        req_valid    = 1'b0;
        prefix_ready = 1'b0;
        checks++; if (fib_out_bit !== 1'b1) begin failures++; $display("FAIL conc_strobe got %b want 1", fib_out_bit); end
        checks++; if (start_send_to_pit !== 1'b0 || rejected !== 1'b0) begin failures++; $display("FAIL conc_rx got %b/%b want 0/0", start_send_to_pit, rejected); end
        if (fib_out_bit === 1'b1 && tx_q.size() > 0) begin
            te = tx_q.pop_front();
            checks++; if (pit_in_prefix !== te.p || pit_in_len !== te.l) begin failures++; $display("FAIL conc_tx got %h/%0d want %h/%0d", pit_in_prefix, pit_in_len, te.p, te.l); end
        end
        for (int i = 0; i < 4; i++) begin
            out_data = d[8*i +: 8];
            step();
        end
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL conc_valid got %b want 1", rsp_valid); end
        if (rsp_valid === 1'b1 && rx_q.size() > 0) begin
            re = rx_q.pop_front();
            checks++; if (rsp_data !== re.d || rsp_prefix !== re.p || rsp_len !== re.l) begin failures++; $display("FAIL conc_capture got %h/%h/%0d want %h/%h/%0d", rsp_data, rsp_prefix, rsp_len, re.d, re.p, re.l); end
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || start_send_to_pit !== 1'b1) begin failures++; $display("FAIL conc_release got %b/%b want 0/1", rsp_valid, start_send_to_pit); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        prefix_ready   = 1'b1;
        pit_out_prefix = 64'h77;
        pit_out_len    = 6'd7;
        step();
        prefix_ready = 1'b0;
        out_data     = 8'h55;
        step();
        out_data = 8'h66;
        step();
        rst = 1'b1;
        step();
        rst     = 1'b0;
        rej_exp = 0;
        checks++; if (rsp_valid !== 1'b0 || start_send_to_pit !== 1'b1) begin failures++; $display("FAIL mid_rst_state got %b/%b want 0/1", rsp_valid, start_send_to_pit); end
        checks++; if (rsp_data !== 32'd0 || reject_count !== 8'd0) begin failures++; $display("FAIL mid_rst_clear got %h/%0d want 0/0", rsp_data, reject_count); end
        d = 32'h0403_0201;
        prefix_ready   = 1'b1;
        pit_out_prefix = 64'h3C;
        pit_out_len    = 6'd6;
        rx_q.push_back('{64'h3C, 6'd6, d});
        step();
        prefix_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            out_data = d[8*i +: 8];
            step();
        end
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_fresh_valid got %b want 1", rsp_valid); end
        if (rsp_valid === 1'b1 && rx_q.size() > 0) begin
            re = rx_q.pop_front();
            checks++; if (rsp_data !== re.d || rsp_prefix !== re.p || rsp_len !== re.l) begin failures++; $display("FAIL mid_fresh_capture got %h/%h/%0d want %h/%h/%0d", rsp_data, rsp_prefix, rsp_len, re.d, re.p, re.l); end
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_interest();
        test_back_to_back();
        test_return();
        test_rejects();
        test_concurrent();
        test_reset_mid();
        checks++;
        if (tx_q.size() != 0 || rx_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d/%0d pending want 0/0", tx_q.size(), rx_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
